// File: rtl/testrig_dii_instr_feed.sv
// -----------------------------------------------------------------------------
// testrig_dii_instr_feed
//
// Instruction-side Direct Instruction Injection feeder for the TestRIG build of
// the CHERIoT Ibex top. Instruction words streamed from the harness are queued
// in a circular FIFO. Every core fetch request is answered with the next queued
// word, regardless of the fetch address, over the req/gnt/rvalid protocol.
// Fetch is stalled (grant withheld) while the queue is empty.
//
// Ports:
//   clk_i, rst_ni         core clock, asynchronous active-low reset
//   flush_i               synchronous flush, discards all queued words
//   dii_valid_i           harness offers dii_insn_i
//   dii_insn_i  [31:0]    offered instruction word
//   dii_ready_o           word accepted this cycle (when valid)
//   instr_req_i           core fetch request
//   instr_addr_i [31:0]   fetch address, ignored
//   instr_gnt_o           fetch granted, head word popped this cycle
//   instr_rvalid_o        response valid (one cycle after grant)
//   instr_rdata_o [32:0]  response data, bit 32 (tag) is always 0
//   instr_rdata_intg_o [6:0]  inverted SECDED(39,32) check bits of rdata[31:0]
//   instr_err_o           bus error, always 0
//   fifo_count_o          number of queued words
//   delivered_cnt_o [31:0] responses delivered since reset (wraps)
// -----------------------------------------------------------------------------
module testrig_dii_instr_feed #(
    parameter int unsigned FifoDepth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           dii_valid_i,
    input  logic [31:0]                    dii_insn_i,
    output logic                           dii_ready_o,
    input  logic                           instr_req_i,
    input  logic [31:0]                    instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [32:0]                    instr_rdata_o,
    output logic [6:0]                     instr_rdata_intg_o,
    output logic                           instr_err_o,
    output logic [$clog2(FifoDepth+1)-1:0] fifo_count_o,
    output logic [31:0]                    delivered_cnt_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    // Inverted SECDED(39,32) encoder: check bits only. The inversion makes the
    // encoding of an all-zero word 7'h2A rather than 7'h00.
    function automatic logic [6:0] secded_inv_39_32_chk(input logic [31:0] d);
        logic [6:0] p;
        p[0] = ^(d & 32'h2606BD25);
        p[1] = ^(d & 32'hDEBA8050);
        p[2] = ^(d & 32'h413D89AA);
        p[3] = ^(d & 32'h31234ED1);
        p[4] = ^(d & 32'hC2C1323B);
        p[5] = ^(d & 32'h2DCC624C);
        p[6] = ^(d & 32'h98505586);
        return p ^ 7'h2A;
    endfunction

    // Pointer increment that wraps at FifoDepth, also for non-power-of-two depths.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]     mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic [31:0]     delivered_q;

    logic push;
    logic pop;

    // The fetch address carries no information for the feeder.
    logic unused_addr;
    assign unused_addr = ^instr_addr_i;

    assign dii_ready_o = !flush_i && (count_q < CntW'(FifoDepth));
    assign instr_gnt_o = instr_req_i && !flush_i && (count_q != '0);

    assign push = dii_valid_i && dii_ready_o;
    assign pop  = instr_gnt_o;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;  // idle, or push and pop together
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; a slot is only ever read after
    // it has been written, so clearing it would buy nothing.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= dii_insn_i;
    end

    // Response register. Grant is already suppressed during flush, so a
    // response granted in the cycle before a flush still completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            delivered_q <= '0;
        end else begin
            rvalid_q <= pop;
            if (pop)      rdata_q     <= mem_q[rd_ptr_q];
            if (rvalid_q) delivered_q <= delivered_q + 32'd1;
        end
    end

    assign instr_rvalid_o     = rvalid_q;
    assign instr_rdata_o      = {1'b0, rdata_q};
    assign instr_rdata_intg_o = secded_inv_39_32_chk(rdata_q);
    assign instr_err_o        = 1'b0;
    assign fifo_count_o       = count_q;
    assign delivered_cnt_o    = delivered_q;

endmodule

// File: tb/tb_testrig_dii_instr_feed.sv
// -----------------------------------------------------------------------------
// tb_testrig_dii_instr_feed
//
// Directed self-checking bench for testrig_dii_instr_feed (FifoDepth = 8).
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns after
// the inputs settle, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_testrig_dii_instr_feed;

    localparam int unsigned Depth = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        dii_valid_i;
    logic [31:0] dii_insn_i;
    logic        dii_ready_o;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [32:0] instr_rdata_o;
    logic [6:0]  instr_rdata_intg_o;
    logic        instr_err_o;
    logic [3:0]  fifo_count_o;
    logic [31:0] delivered_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sb[$];
    logic [31:0] exp_word;

    testrig_dii_instr_feed #(.FifoDepth(Depth)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .dii_valid_i        (dii_valid_i),
        .dii_insn_i         (dii_insn_i),
        .dii_ready_o        (dii_ready_o),
        .instr_req_i        (instr_req_i),
        .instr_addr_i       (instr_addr_i),
        .instr_gnt_o        (instr_gnt_o),
        .instr_rvalid_o     (instr_rvalid_o),
        .instr_rdata_o      (instr_rdata_o),
        .instr_rdata_intg_o (instr_rdata_intg_o),
        .instr_err_o        (instr_err_o),
        .fifo_count_o       (fifo_count_o),
        .delivered_cnt_o    (delivered_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference inverted SECDED(39,32) check-bit encoder.
    function automatic logic [6:0] ref_intg(input logic [31:0] d);
        logic [6:0] p;
        p[0] = ^(d & 32'h2606BD25);
        p[1] = ^(d & 32'hDEBA8050);
        p[2] = ^(d & 32'h413D89AA);
        p[3] = ^(d & 32'h31234ED1);
        p[4] = ^(d & 32'hC2C1323B);
        p[5] = ^(d & 32'h2DCC624C);
        p[6] = ^(d & 32'h98505586);
        return p ^ 7'h2A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] word);
        check({tag, ".rvalid"}, 64'(instr_rvalid_o), 64'd1);
        check({tag, ".rdata"}, 64'(instr_rdata_o), 64'({1'b0, word}));
        check({tag, ".intg"}, 64'(instr_rdata_intg_o), 64'(ref_intg(word)));
    endtask

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        dii_valid_i  = 1'b0;
        dii_insn_i   = '0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h8000_0000;
        #23;
        // ---------------- reset values ----------------
        check("rst.ready",     64'(dii_ready_o),        64'd1);
        check("rst.gnt",       64'(instr_gnt_o),        64'd0);
        check("rst.rvalid",    64'(instr_rvalid_o),     64'd0);
        check("rst.rdata",     64'(instr_rdata_o),      64'd0);
        check("rst.intg",      64'(instr_rdata_intg_o), 64'h2A);
        check("rst.err",       64'(instr_err_o),        64'd0);
        check("rst.count",     64'(fifo_count_o),       64'd0);
        check("rst.delivered", 64'(delivered_cnt_o),    64'd0);
        rst_ni = 1'b1;
        tick();

        // ---------------- basic two-word feed ----------------
        dii_valid_i = 1'b1; dii_insn_i = 32'h0000_0013;
        settle();
        check("t1.ready0", 64'(dii_ready_o), 64'd1);
        tick();
        dii_insn_i = 32'h0010_0093;
        tick();
        dii_valid_i = 1'b0;
        check("t1.count", 64'(fifo_count_o), 64'd2);
        instr_req_i = 1'b1;
        settle();
        check("t1.gnt0", 64'(instr_gnt_o), 64'd1);
        tick();
        check_resp("t1.r0", 32'h0000_0013);
        check("t1.gnt1", 64'(instr_gnt_o), 64'd1);
        tick();
        check_resp("t1.r1", 32'h0010_0093);
        check("t1.gnt2", 64'(instr_gnt_o), 64'd0);
        tick();
        check("t1.rvalid_end", 64'(instr_rvalid_o), 64'd0);
        check("t1.delivered", 64'(delivered_cnt_o), 64'd2);

        // ---------------- empty queue stall ----------------
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("t2.stall_gnt%0d", i), 64'(instr_gnt_o), 64'd0);
            check($sformatf("t2.stall_rv%0d", i), 64'(instr_rvalid_o), 64'd0);
            tick();
        end
        dii_valid_i = 1'b1; dii_insn_i = 32'hDEAD_BEEF;
        settle();
        check("t2.no_bypass", 64'(instr_gnt_o), 64'd0);
        tick();
        dii_valid_i = 1'b0;
        settle();
        check("t2.gnt", 64'(instr_gnt_o), 64'd1);
        tick();
        check_resp("t2.resp", 32'hDEAD_BEEF);
        check("t2.gnt_after", 64'(instr_gnt_o), 64'd0);
        instr_req_i = 1'b0;
        tick();

        // ---------------- full queue ----------------
        dii_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dii_insn_i = 32'h0000_1000 + 32'(i);
            tick();
        end
        dii_insn_i = 32'h0000_1008;
        settle();
        check("t3.count_full", 64'(fifo_count_o), 64'd8);
        check("t3.ready_full", 64'(dii_ready_o),  64'd0);
        instr_req_i = 1'b1;
        settle();
        check("t3.gnt_full",   64'(instr_gnt_o), 64'd1);
        check("t3.ready_full2", 64'(dii_ready_o), 64'd0);
        tick();
        instr_req_i = 1'b0;
        settle();
        check_resp("t3.first", 32'h0000_1000);
        check("t3.count7",  64'(fifo_count_o), 64'd7);
        check("t3.reopen",  64'(dii_ready_o),  64'd1);
        tick();
        dii_valid_i = 1'b0;
        check("t3.count_refull", 64'(fifo_count_o), 64'd8);
        instr_req_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_resp($sformatf("t3.drain%0d", i), 32'h0000_1000 + 32'(i));
        end
        settle();
        check("t3.gnt_empty", 64'(instr_gnt_o), 64'd0);
        instr_req_i = 1'b0;
        tick();

        // ---------------- concurrent push/pop at count 3 ----------------
        dii_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dii_insn_i = 32'h0000_2000 + 32'(i);
            sb.push_back(dii_insn_i);
            tick();
        end
        check("t4.count3", 64'(fifo_count_o), 64'd3);
        instr_req_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            dii_insn_i = 32'h0000_2003 + 32'(c);
            settle();
            check($sformatf("t4.gnt%0d", c),   64'(instr_gnt_o), 64'd1);
            check($sformatf("t4.ready%0d", c), 64'(dii_ready_o), 64'd1);
            sb.push_back(dii_insn_i);
            tick();
            exp_word = sb.pop_front();
            check($sformatf("t4.count%0d", c), 64'(fifo_count_o), 64'd3);
            check_resp($sformatf("t4.sb%0d", c), exp_word);
        end
        dii_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_word = sb.pop_front();
            check_resp($sformatf("t4.tail%0d", c), exp_word);
        end
        instr_req_i = 1'b0;
        check("t4.count_end", 64'(fifo_count_o), 64'd0);
        tick();

        // ---------------- flush after grant ----------------
        dii_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dii_insn_i = 32'h0000_3000 + 32'(i);
            tick();
        end
        dii_valid_i = 1'b0;
        instr_req_i = 1'b1;
        settle();
        check("t5.gnt_n", 64'(instr_gnt_o), 64'd1);
        tick();
        flush_i = 1'b1; dii_valid_i = 1'b1; dii_insn_i = 32'h0000_3FFF;
        settle();
        check_resp("t5.resp_n1", 32'h0000_3000);
        check("t5.gnt_flush",   64'(instr_gnt_o), 64'd0);
        check("t5.ready_flush", 64'(dii_ready_o), 64'd0);
        tick();
        flush_i = 1'b0; dii_valid_i = 1'b0; instr_req_i = 1'b0;
        check("t5.count_n2",  64'(fifo_count_o),   64'd0);
        check("t5.rvalid_n2", 64'(instr_rvalid_o), 64'd0);
        dii_valid_i = 1'b1; dii_insn_i = 32'h0000_4000;
        tick();
        dii_valid_i = 1'b0;
        instr_req_i = 1'b1;
        settle();
        check("t5.gnt_new", 64'(instr_gnt_o), 64'd1);
        tick();
        check_resp("t5.resp_new", 32'h0000_4000);
        instr_req_i = 1'b0;
        tick();
        check("t5.delivered", 64'(delivered_cnt_o), 64'd27);

        // ---------------- reset with a response pending ----------------
        dii_valid_i = 1'b1; dii_insn_i = 32'h0000_5000;
        tick();
        dii_valid_i = 1'b0;
        instr_req_i = 1'b1;
        settle();
        check("t6.gnt", 64'(instr_gnt_o), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("t6.rvalid",    64'(instr_rvalid_o),     64'd0);
        check("t6.gnt_rst",   64'(instr_gnt_o),        64'd0);
        check("t6.rdata",     64'(instr_rdata_o),      64'd0);
        check("t6.intg",      64'(instr_rdata_intg_o), 64'h2A);
        check("t6.count",     64'(fifo_count_o),       64'd0);
        check("t6.delivered", 64'(delivered_cnt_o),    64'd0);
        check("t6.ready",     64'(dii_ready_o),        64'd1);
        tick();
        check("t6.rvalid_in_rst", 64'(instr_rvalid_o), 64'd0);
        rst_ni = 1'b1;
        instr_req_i = 1'b0;
        tick();
        check("t6.rvalid_after", 64'(instr_rvalid_o), 64'd0);
        check("t6.count_after",  64'(fifo_count_o),   64'd0);
        check("t6.err",          64'(instr_err_o),    64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
